// File: rtl/mult_pkg.sv
// Shared widths, state encoding and limits for the HI/LO capture block.
package mult_pkg;

    localparam int unsigned DW          = 32;
    localparam int unsigned PW          = 2 * DW;
    localparam int unsigned MUL_LAT_MAX = 15;
    localparam int unsigned CntW        = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StCapt
    } hilo_state_t;

endpackage

// File: rtl/hilo_capture_if.sv
// Datapath-side bus of the HI/LO capture block: product input, mfhi/mflo/mthi/mtlo, status.
interface hilo_capture_if;
    import mult_pkg::*;

    logic          start;
    logic [PW-1:0] Y;
    logic          rd_hi;
    logic          rd_lo;
    logic          wr_hi;
    logic          wr_lo;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          stall;
    logic          done;
    logic          overrun;
    logic [DW-1:0] HI;
    logic [DW-1:0] LO;

    modport master (
        output start, Y, rd_hi, rd_lo, wr_hi, wr_lo, wr_data,
        input  rd_data, rd_valid, busy, stall, done, overrun, HI, LO
    );

    modport slave (
        input  start, Y, rd_hi, rd_lo, wr_hi, wr_lo, wr_data,
        output rd_data, rd_valid, busy, stall, done, overrun, HI, LO
    );

endinterface

// File: rtl/mul_lat_counter.sv
// Multiplier latency down-counter: load, decrement, and a flag when the count reaches one.
module mul_lat_counter
    import mult_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [CntW-1:0] load_val_i,
    input  logic            dec_i,
    output logic            last_o
);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/hilo_capture.sv
// HI/LO register pair fed by the multiplier, with latency tracking and mfhi/mflo/mthi/mtlo access.
// Define HILO_BYPASS_EN to serve reads from Y during the capture cycle instead of stalling.
module hilo_capture
    import mult_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input logic           clk,
    input logic           reset,
    hilo_capture_if.slave bus
);

    localparam logic [CntW-1:0] LoadVal    = CntW'(MUL_LAT - 1);
    localparam bit              MultiCycle = (MUL_LAT > 1);

    hilo_state_t   state_d, state_q;
    logic [DW-1:0] hi_d, hi_q, lo_d, lo_q, rd_data_d, rd_data_q;
    logic          rd_valid_d, rd_valid_q, done_d, done_q, overrun_d, overrun_q;
    logic          rd_req, accept, cnt_last;

    assign rd_req = bus.rd_hi | bus.rd_lo;
    // A new start is taken in IDLE and, back-to-back, in the capture cycle.
    assign accept = bus.start & ((state_q == StIdle) | (state_q == StCapt));

    mul_lat_counter u_cnt (
        .clk_i      (clk),
        .rst_ni     (reset),
        .load_i     (accept & MultiCycle),
        .load_val_i (LoadVal),
        .dec_i      (state_q == StWait),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        overrun_d  = overrun_q;
        unique case (state_q)
            StIdle: begin
                if (bus.rd_hi) begin
                    rd_data_d  = hi_q;
                    rd_valid_d = 1'b1;
                end else if (bus.rd_lo) begin
                    rd_data_d  = lo_q;
                    rd_valid_d = 1'b1;
                end
                if (bus.wr_hi) hi_d = bus.wr_data;
                if (bus.wr_lo) lo_d = bus.wr_data;
                if (bus.start) state_d = MultiCycle ? StWait : StCapt;
            end
            StWait: begin
                if (bus.start) overrun_d = 1'b1;
                if (cnt_last) state_d = StCapt;
            end
            StCapt: begin
                hi_d   = bus.Y[PW-1:DW];
                lo_d   = bus.Y[DW-1:0];
                done_d = 1'b1;
`ifdef HILO_BYPASS_EN
                if (bus.rd_hi) begin
                    rd_data_d  = bus.Y[PW-1:DW];
                    rd_valid_d = 1'b1;
                end else if (bus.rd_lo) begin
                    rd_data_d  = bus.Y[DW-1:0];
                    rd_valid_d = 1'b1;
                end
`endif
                if (bus.start) begin
                    state_d = MultiCycle ? StWait : StCapt;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef HILO_BYPASS_EN
    assign bus.stall = rd_req & (state_q == StWait);
`else
    assign bus.stall = rd_req & (state_q != StIdle);
`endif

    assign bus.busy     = (state_q != StIdle);
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.done     = done_q;
    assign bus.overrun  = overrun_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;

endmodule
